// File: rtl/paint_brush.sv
// Drawing brush: button-driven cursor, live footprint preview on the RGB
// stream, and a latched stamp engine that rasterises the brush footprint
// into the framebuffer write FIFO one pixel per enabled cycle.
module paint_brush #(
   parameter int unsigned RESOLUTION_H = 640,
   parameter int unsigned RESOLUTION_V = 480,
   parameter int unsigned HPOS_WIDTH = 10,
   parameter int unsigned VPOS_WIDTH = 10,
   parameter int unsigned COLOR_WIDTH = 3,
   parameter int unsigned SLOWNESS = 16,
   parameter logic [COLOR_WIDTH-1:0] BRUSH_COLOR = 3'b101,
   parameter int unsigned BRUSH_BASE_SIZE = 10,
   parameter int unsigned SIZE_STEP = 10,
   parameter int unsigned BRUSH_MAX_SIZE = 30,
   parameter int unsigned INIT_XPOS = RESOLUTION_H / 2,
   parameter int unsigned INIT_YPOS = RESOLUTION_V / 2,
   parameter int unsigned SIZE_WIDTH = $clog2(BRUSH_MAX_SIZE + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             BTN,
   input  logic                   size_next,
   input  logic                   color_next,
   input  logic                   shape_next,
   input  logic                   display_on,
   input  logic [HPOS_WIDTH-1:0]  hpos,
   input  logic [VPOS_WIDTH-1:0]  vpos,
   input  logic [COLOR_WIDTH-1:0] FB_RGB,
   input  logic                   memenable,
   input  logic                   fifofull,
   output logic [COLOR_WIDTH-1:0] rgb,
   output logic [COLOR_WIDTH-1:0] writergb,
   output logic                   fifopush,
   output logic [HPOS_WIDTH-1:0]  writecounter_x,
   output logic [VPOS_WIDTH-1:0]  writecounter_y,
   output logic                   busy,
   output logic [1:0]             shape,
   output logic [SIZE_WIDTH-1:0]  brush_size
);

   localparam logic StIdle = 1'b0;
   localparam logic StScan = 1'b1;

   localparam logic [1:0] ShDiamond = 2'd1;
   localparam logic [1:0] ShCircle  = 2'd2;
   localparam logic [1:0] ShEraser  = 2'd3;

   localparam int unsigned SUM_W = (HPOS_WIDTH > VPOS_WIDTH ? HPOS_WIDTH : VPOS_WIDTH) + 2;
   localparam int unsigned SQ_W  = 2 * SIZE_WIDTH + 1;

   localparam logic [SIZE_WIDTH-1:0]  SZ_BASE = SIZE_WIDTH'(BRUSH_BASE_SIZE);
   localparam logic [SIZE_WIDTH-1:0]  SZ_STEP = SIZE_WIDTH'(SIZE_STEP);
   localparam logic [SIZE_WIDTH-1:0]  SZ_MAX  = SIZE_WIDTH'(BRUSH_MAX_SIZE);
   localparam logic [HPOS_WIDTH-1:0]  H_LAST  = HPOS_WIDTH'(RESOLUTION_H - 1);
   localparam logic [VPOS_WIDTH-1:0]  V_LAST  = VPOS_WIDTH'(RESOLUTION_V - 1);
   localparam logic [COLOR_WIDTH-1:0] COL_MAX = '1;
   localparam logic [COLOR_WIDTH-1:0] COL_ONE = COLOR_WIDTH'(1);

   // Live brush state
   logic [HPOS_WIDTH-1:0]  cx_q, cx_d;
   logic [VPOS_WIDTH-1:0]  cy_q, cy_d;
   logic [SIZE_WIDTH-1:0]  r_q, r_d;
   logic [COLOR_WIDTH-1:0] color_q, color_d;
   logic [1:0]             shape_q, shape_d;
   logic [SLOWNESS-1:0]    div_q, div_d;
   logic [COLOR_WIDTH-1:0] rgb_q, rgb_d;

   // Stamp engine state
   logic                   state_q, state_d;
   logic                   busy_q, busy_d;
   logic                   fifopush_q, fifopush_d;
   logic [HPOS_WIDTH-1:0]  wcx_q, wcx_d;
   logic [VPOS_WIDTH-1:0]  wcy_q, wcy_d;
   logic [COLOR_WIDTH-1:0] writergb_q, writergb_d;
   logic [HPOS_WIDTH-1:0]  lcx_q, lcx_d, sx_q, sx_d;
   logic [VPOS_WIDTH-1:0]  lcy_q, lcy_d, sy_q, sy_d;
   logic [SIZE_WIDTH-1:0]  lr_q, lr_d;
   logic [1:0]             lshape_q, lshape_d;

   // Squares are only formed once the box test has bounded |dx|,|dy| by r.
   function automatic logic in_footprint(
      input logic [HPOS_WIDTH-1:0] px,
      input logic [VPOS_WIDTH-1:0] py,
      input logic [HPOS_WIDTH-1:0] ox,
      input logic [VPOS_WIDTH-1:0] oy,
      input logic [SIZE_WIDTH-1:0] rad,
      input logic [1:0]            shp
   );
      logic signed [HPOS_WIDTH:0] dx;
      logic signed [VPOS_WIDTH:0] dy;
      logic [HPOS_WIDTH:0]        adx;
      logic [VPOS_WIDTH:0]        ady;
      logic [SUM_W-1:0]           sum;
      logic [SQ_W-1:0]            sq_sum;
      logic [SQ_W-1:0]            r_sq;
      logic                       box;
      logic                       hit;
      dx     = $signed({1'b0, px}) - $signed({1'b0, ox});
      dy     = $signed({1'b0, py}) - $signed({1'b0, oy});
      adx    = dx[HPOS_WIDTH] ? $unsigned(-dx) : $unsigned(dx);
      ady    = dy[VPOS_WIDTH] ? $unsigned(-dy) : $unsigned(dy);
      box    = (adx <= (HPOS_WIDTH + 1)'(rad)) && (ady <= (VPOS_WIDTH + 1)'(rad));
      sum    = SUM_W'(adx) + SUM_W'(ady);
      sq_sum = SQ_W'(adx[SIZE_WIDTH-1:0]) * SQ_W'(adx[SIZE_WIDTH-1:0])
             + SQ_W'(ady[SIZE_WIDTH-1:0]) * SQ_W'(ady[SIZE_WIDTH-1:0]);
      r_sq   = SQ_W'(rad) * SQ_W'(rad);
      case (shp)
         ShDiamond: hit = sum <= SUM_W'(rad);
         ShCircle:  hit = box && (sq_sum <= r_sq);
         default:   hit = box;
      endcase
      return hit;
   endfunction

   logic                  tick;
   logic                  live_hit;
   logic                  scan_hit;
   logic [HPOS_WIDTH-1:0] nx, x_lo, x_hi, x_first, x_last;
   logic [VPOS_WIDTH-1:0] ny, y_lo, y_hi, y_last;

   // Cursor movement, brush parameter cycling and the preview pixel
   always_comb begin
      tick    = display_on && (div_q == '0);
      div_d   = display_on ? div_q + 1'b1 : div_q;
      r_d     = r_q;
      color_d = color_q;
      shape_d = shape_q;
      if (size_next) r_d = (r_q == SZ_MAX) ? SZ_BASE : r_q + SZ_STEP;
      if (color_next) color_d = (color_q == COL_MAX) ? COL_ONE : color_q + 1'b1;
      if (shape_next) shape_d = shape_q + 2'd1;

      // Step legality uses the current radius, then re-clamp to the new one.
      nx = cx_q;
      ny = cy_q;
      if (tick && BTN[0]) begin
         if (BTN[2]) begin
            if (cx_q < H_LAST - HPOS_WIDTH'(r_q)) nx = cx_q + 1'b1;
         end else if (cx_q > HPOS_WIDTH'(r_q)) begin
            nx = cx_q - 1'b1;
         end
      end
      if (tick && BTN[1]) begin
         if (BTN[2]) begin
            if (cy_q < V_LAST - VPOS_WIDTH'(r_q)) ny = cy_q + 1'b1;
         end else if (cy_q > VPOS_WIDTH'(r_q)) begin
            ny = cy_q - 1'b1;
         end
      end
      x_lo = HPOS_WIDTH'(r_d);
      x_hi = H_LAST - HPOS_WIDTH'(r_d);
      y_lo = VPOS_WIDTH'(r_d);
      y_hi = V_LAST - VPOS_WIDTH'(r_d);
      cx_d = (nx < x_lo) ? x_lo : ((nx > x_hi) ? x_hi : nx);
      cy_d = (ny < y_lo) ? y_lo : ((ny > y_hi) ? y_hi : ny);

      live_hit = in_footprint(hpos, vpos, cx_q, cy_q, r_q, shape_q);
      rgb_d    = '0;
      if (display_on) begin
         if (live_hit) rgb_d = (shape_q == ShEraser) ? COL_MAX : color_q;
         else rgb_d = FB_RGB;
      end
   end

   // Stamp engine: latch the brush, then raster the bounding box
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      fifopush_d = 1'b0;
      wcx_d      = wcx_q;
      wcy_d      = wcy_q;
      writergb_d = writergb_q;
      lcx_d      = lcx_q;
      lcy_d      = lcy_q;
      lr_d       = lr_q;
      lshape_d   = lshape_q;
      sx_d       = sx_q;
      sy_d       = sy_q;
      scan_hit   = in_footprint(sx_q, sy_q, lcx_q, lcy_q, lr_q, lshape_q);
      x_first    = lcx_q - HPOS_WIDTH'(lr_q);
      x_last     = lcx_q + HPOS_WIDTH'(lr_q);
      y_last     = lcy_q + VPOS_WIDTH'(lr_q);
      case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            if (BTN[3] && memenable) begin
               lcx_d      = cx_q;
               lcy_d      = cy_q;
               lr_d       = r_q;
               lshape_d   = shape_q;
               writergb_d = (shape_q == ShEraser) ? '0 : color_q;
               sx_d       = cx_q - HPOS_WIDTH'(r_q);
               sy_d       = cy_q - VPOS_WIDTH'(r_q);
               busy_d     = 1'b1;
               state_d    = StScan;
            end
         end
         default: begin
            if (memenable && !fifofull) begin
               wcx_d      = sx_q;
               wcy_d      = sy_q;
               fifopush_d = scan_hit;
               if (sx_q == x_last) begin
                  sx_d = x_first;
                  if (sy_q == y_last) state_d = StIdle;
                  else sy_d = sy_q + 1'b1;
               end else begin
                  sx_d = sx_q + 1'b1;
               end
            end
         end
      endcase
   end

   // Brush and preview registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cx_q    <= HPOS_WIDTH'(INIT_XPOS);
         cy_q    <= VPOS_WIDTH'(INIT_YPOS);
         r_q     <= SZ_BASE;
         color_q <= BRUSH_COLOR;
         shape_q <= '0;
         div_q   <= '0;
         rgb_q   <= '0;
      end else begin
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         r_q     <= r_d;
         color_q <= color_d;
         shape_q <= shape_d;
         div_q   <= div_d;
         rgb_q   <= rgb_d;
      end
   end

   // Stamp engine registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         busy_q     <= 1'b0;
         fifopush_q <= 1'b0;
         wcx_q      <= '0;
         wcy_q      <= '0;
         writergb_q <= '0;
         lcx_q      <= '0;
         lcy_q      <= '0;
         lr_q       <= '0;
         lshape_q   <= '0;
         sx_q       <= '0;
         sy_q       <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         fifopush_q <= fifopush_d;
         wcx_q      <= wcx_d;
         wcy_q      <= wcy_d;
         writergb_q <= writergb_d;
         lcx_q      <= lcx_d;
         lcy_q      <= lcy_d;
         lr_q       <= lr_d;
         lshape_q   <= lshape_d;
         sx_q       <= sx_d;
         sy_q       <= sy_d;
      end
   end

   assign rgb            = rgb_q;
   assign writergb       = writergb_q;
   assign fifopush       = fifopush_q;
   assign writecounter_x = wcx_q;
   assign writecounter_y = wcy_q;
   assign busy           = busy_q;
   assign shape          = shape_q;
   assign brush_size     = r_q;

endmodule

// File: tb/tb_paint_brush.sv
// Directed bench for paint_brush: cursor moves and clamping, brush cycling,
// preview colours, square/circle/eraser stamps, backpressure and reset abort.
module tb_paint_brush;

   logic       clk;
   logic       reset;
   logic [3:0] BTN;
   logic       size_next, color_next, shape_next;
   logic       display_on;
   logic [9:0] hpos, vpos;
   logic [2:0] FB_RGB;
   logic       memenable, fifofull;
   logic [2:0] rgb, writergb;
   logic       fifopush;
   logic [9:0] writecounter_x, writecounter_y;
   logic       busy;
   logic [1:0] shape;
   logic [4:0] brush_size;

   paint_brush #(.SLOWNESS(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .BTN            (BTN),
      .size_next      (size_next),
      .color_next     (color_next),
      .shape_next     (shape_next),
      .display_on     (display_on),
      .hpos           (hpos),
      .vpos           (vpos),
      .FB_RGB         (FB_RGB),
      .memenable      (memenable),
      .fifofull       (fifofull),
      .rgb            (rgb),
      .writergb       (writergb),
      .fifopush       (fifopush),
      .writecounter_x (writecounter_x),
      .writecounter_y (writecounter_y),
      .busy           (busy),
      .shape          (shape),
      .brush_size     (brush_size)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Bench-side expectation of the live brush
   int         ex_x, ex_y, ex_r, ex_shape;
   logic [2:0] ex_col;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit m_inside(input int dx, input int dy, input int r, input int s);
      int ax, ay;
      ax = (dx < 0) ? -dx : dx;
      ay = (dy < 0) ? -dy : dy;
      if (s == 1) return (ax + ay) <= r;
      if (s == 2) return (dx * dx + dy * dy) <= r * r;
      return (ax <= r) && (ay <= r);
   endfunction

   task automatic pulse(input int which);
      size_next  = (which == 0);
      color_next = (which == 1);
      shape_next = (which == 2);
      step();
      size_next  = 1'b0;
      color_next = 1'b0;
      shape_next = 1'b0;
   endtask

   // Every 4 consecutive display_on cycles contain exactly one tick.
   task automatic move(input logic [3:0] b, input int ticks);
      BTN = b;
      display_on = 1'b1;
      repeat (4 * ticks) step();
      BTN = 4'b0000;
   endtask

   task automatic probe(input string tag, input int h, input int v);
      logic [2:0] exp;
      hpos = 10'(h);
      vpos = 10'(v);
      display_on = 1'b1;
      step();
      if (m_inside(h - ex_x, v - ex_y, ex_r, ex_shape)) exp = (ex_shape == 3) ? 3'b111 : ex_col;
      else exp = FB_RGB;
      check(tag, 32'(rgb), 32'(exp));
   endtask

   task automatic check_cursor(input string tag);
      probe({tag, " x+r"}, ex_x + ex_r, ex_y);
      probe({tag, " x+r+1"}, ex_x + ex_r + 1, ex_y);
      probe({tag, " x-r"}, ex_x - ex_r, ex_y);
      probe({tag, " x-r-1"}, ex_x - ex_r - 1, ex_y);
      probe({tag, " y+r"}, ex_x, ex_y + ex_r);
      probe({tag, " y+r+1"}, ex_x, ex_y + ex_r + 1);
      probe({tag, " y-r"}, ex_x, ex_y - ex_r);
      probe({tag, " y-r-1"}, ex_x, ex_y - ex_r - 1);
   endtask

   task automatic do_stamp(input string tag, input int cnt_exp, input logic [2:0] wrgb_exp,
                           input bit stall, input int abort_at);
      int   qx[$];
      int   qy[$];
      int   idx, en_cnt, n_scan, extra;
      bit   done;
      logic ff;
      for (int y = ex_y - ex_r; y <= ex_y + ex_r; y++)
         for (int x = ex_x - ex_r; x <= ex_x + ex_r; x++)
            if (m_inside(x - ex_x, y - ex_y, ex_r, ex_shape)) begin
               qx.push_back(x);
               qy.push_back(y);
            end
      n_scan = (2 * ex_r + 1) * (2 * ex_r + 1);
      display_on = 1'b0;
      memenable = 1'b1;
      fifofull = 1'b0;
      BTN = 4'b1000;
      step();
      BTN = 4'b0000;
      check({tag, " busy at latch"}, 32'(busy), 32'd1);
      idx = 0;
      en_cnt = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 4 * n_scan + 20 && !done; cyc++) begin
         ff = stall ? 1'($urandom_range(0, 1)) : 1'b0;
         fifofull = ff;
         step();
         if (ff) check({tag, " push after full"}, 32'(fifopush), 32'd0);
         else en_cnt++;
         if (fifopush) begin
            if (idx < qx.size()) begin
               check({tag, " addr x"}, 32'(writecounter_x), 32'(qx[idx]));
               check({tag, " addr y"}, 32'(writecounter_y), 32'(qy[idx]));
               check({tag, " writergb"}, 32'(writergb), 32'(wrgb_exp));
            end else begin
               check({tag, " extra push"}, 32'(idx), 32'(qx.size()));
            end
            idx++;
         end
         if (abort_at > 0 && idx == abort_at) begin
            fifofull = 1'b0;
            reset = 1'b1;
            step();
            reset = 1'b0;
            check({tag, " push after reset"}, 32'(fifopush), 32'd0);
            check({tag, " busy after reset"}, 32'(busy), 32'd0);
            extra = 0;
            repeat (30) begin
               step();
               if (fifopush) extra++;
            end
            check({tag, " pushes after reset"}, 32'(extra), 32'd0);
            check({tag, " idle after reset"}, 32'(busy), 32'd0);
            ex_x = 320; ex_y = 240; ex_r = 10; ex_shape = 0; ex_col = 3'b101;
            done = 1'b1;
         end else if (en_cnt == n_scan) begin
            check({tag, " busy on last scan"}, 32'(busy), 32'd1);
            fifofull = 1'b0;
            step();
            check({tag, " busy drop"}, 32'(busy), 32'd0);
            check({tag, " no push at drop"}, 32'(fifopush), 32'd0);
            done = 1'b1;
         end
      end
      fifofull = 1'b0;
      if (!done) check({tag, " timeout"}, 32'(done), 32'd1);
      if (abort_at == 0) check({tag, " push count"}, 32'(idx), 32'(cnt_exp));
   endtask

   initial begin
      reset = 1'b1;
      BTN = 4'b0000;
      size_next = 1'b0;
      color_next = 1'b0;
      shape_next = 1'b0;
      display_on = 1'b0;
      hpos = '0;
      vpos = '0;
      FB_RGB = 3'b010;
      memenable = 1'b0;
      fifofull = 1'b0;
      ex_x = 320; ex_y = 240; ex_r = 10; ex_shape = 0; ex_col = 3'b101;

      step();
      step();
      check("reset rgb", 32'(rgb), 32'd0);
      check("reset fifopush", 32'(fifopush), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset wc_x", 32'(writecounter_x), 32'd0);
      check("reset wc_y", 32'(writecounter_y), 32'd0);
      check("reset shape", 32'(shape), 32'd0);
      check("reset size", 32'(brush_size), 32'd10);
      check("reset writergb", 32'(writergb), 32'd0);
      reset = 1'b0;
      step();
      check("preview blank", 32'(rgb), 32'd0);

      move(4'b0101, 8);
      ex_x = 328;
      check_cursor("move right 8");

      // 318 steps reach x = 10; the last 3 ticks must be ignored
      move(4'b0001, 321);
      ex_x = 10;
      check_cursor("clamp left");

      pulse(0);
      check("size 20", 32'(brush_size), 32'd20);
      ex_r = 20; ex_x = 20;
      check_cursor("reclamp r20");

      pulse(0);
      check("size 30", 32'(brush_size), 32'd30);
      pulse(0);
      check("size wrap", 32'(brush_size), 32'd10);
      ex_r = 10; ex_x = 30;
      check_cursor("after wrap");

      move(4'b0101, 70);
      move(4'b0010, 140);
      ex_x = 100; ex_y = 100;
      check_cursor("at 100,100");

      pulse(1);
      ex_col = 3'b110;
      probe("color 110", 100, 100);
      pulse(1);
      ex_col = 3'b111;
      probe("color 111", 100, 100);
      pulse(1);
      ex_col = 3'b001;
      probe("color wrap", 100, 100);

      do_stamp("square", 441, 3'b001, 1'b0, 0);
      do_stamp("stalled", 441, 3'b001, 1'b1, 0);

      pulse(2);
      check("shape diamond", 32'(shape), 32'd1);
      ex_shape = 1;
      probe("diamond in", 105, 105);
      probe("diamond out", 106, 105);
      probe("diamond tip", 110, 100);

      pulse(2);
      check("shape circle", 32'(shape), 32'd2);
      ex_shape = 2;
      probe("circle out", 108, 108);
      do_stamp("circle", 317, 3'b001, 1'b0, 0);

      pulse(2);
      check("shape eraser", 32'(shape), 32'd3);
      ex_shape = 3;
      probe("eraser preview", 100, 100);
      do_stamp("eraser", 441, 3'b000, 1'b0, 0);

      pulse(2);
      check("shape wrap", 32'(shape), 32'd0);
      ex_shape = 0;
      do_stamp("abort", 441, 3'b001, 1'b0, 50);
      check("abort reset size", 32'(brush_size), 32'd10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/paint_brush.md
# paint_brush

Parametrised second-generation drawing brush for the VGA framebuffer path. It moves a cursor from buttons and overlays a live brush preview on the framebuffer RGB stream. On paint it stamps the brush footprint into the framebuffer write FIFO, one pixel per enabled cycle. It adds selectable shape (square, diamond, circle, eraser), selectable colour, and a latched, stall-safe stamp engine. It sits between button debounce/edge logic and the framebuffer write FIFO, in place of the fixed square brush.

## Interface
- RESOLUTION_H, 640, visible width in pixels
- RESOLUTION_V, 480, visible height in pixels
- HPOS_WIDTH, 10, x coordinate width
- VPOS_WIDTH, 10, y coordinate width
- COLOR_WIDTH, 3, RGB word width
- SLOWNESS, 16, move divider; cursor steps once per 2^SLOWNESS display_on cycles
- BRUSH_COLOR, 3'b101, reset paint colour
- BRUSH_BASE_SIZE, 10, reset and wrap radius
- SIZE_STEP, 10, radius increment
- BRUSH_MAX_SIZE, 30, largest radius
- INIT_XPOS / INIT_YPOS, RESOLUTION_H/2 / RESOLUTION_V/2, reset cursor position
- SIZE_WIDTH, $clog2(BRUSH_MAX_SIZE+1), radius width

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- BTN  in  4  [0] x move, [1] y move, [2] direction (1 = right/down), [3] paint (level)
- size_next, color_next, shape_next  in  1 each  single-cycle pulses
- display_on  in  1  visible-area flag
- hpos / vpos  in  HPOS_WIDTH / VPOS_WIDTH  current scan position
- FB_RGB  in  COLOR_WIDTH  framebuffer pixel at hpos/vpos
- memenable  in  1  write slot available
- fifofull  in  1  FIFO almost-full; at least 1 free entry remains while it is asserted
- rgb  out  COLOR_WIDTH  registered display output
- writergb  out  COLOR_WIDTH  colour for the pushed pixel
- fifopush  out  1  one-cycle write strobe
- writecounter_x / writecounter_y  out  HPOS_WIDTH / VPOS_WIDTH  write address
- busy  out  1  stamp in progress
- shape  out  2  0 square, 1 diamond, 2 circle, 3 eraser
- brush_size  out  SIZE_WIDTH  current radius r

## Operation
- **Reset values:**
  - Cursor = INIT_XPOS/INIT_YPOS; r = BRUSH_BASE_SIZE; colour = BRUSH_COLOR; shape = 0.
  - rgb = 0, fifopush = 0, busy = 0, write address = 0, divider = 0, FSM = IDLE.
- **Divider:**
  - Free-running SLOWNESS-bit counter, incremented only while display_on.
  - A move tick is the cycle where the counter = 0 and display_on = 1.
- **Movement:**
  - On a tick, BTN[0] steps x by ±1 and BTN[1] steps y by ±1; both may step in the same tick.
  - Clamp: r ≤ x ≤ RESOLUTION_H−1−r, and r ≤ y ≤ RESOLUTION_V−1−r. A step that would leave this range is ignored.
- **size_next:**
  - r ← r+SIZE_STEP; if r = BRUSH_MAX_SIZE, r ← BRUSH_BASE_SIZE instead.
  - In the same cycle the cursor is re-clamped into the new legal range.
- **color_next:** colour+1, skipping 0 (max wraps to 1).
- **shape_next:** shape+1 mod 4.
- **Mid-stamp pulses:** size/colour/shape pulses and moves still update the live registers while busy. They do not affect the stamp in flight.
- **Footprint test:** with signed dx = px−cx and dy = py−cy, widths +1 bit, squares in 2·SIZE_WIDTH+1 bits:
  - square/eraser: |dx| ≤ r and |dy| ≤ r
  - diamond: |dx|+|dy| ≤ r
  - circle: dx²+dy² ≤ r²
- **Preview:**
  - rgb ← 0 if !display_on.
  - Else, if (hpos,vpos) is inside the live footprint: colour, or 3'b111 for eraser.
  - Else rgb ← FB_RGB.
- **Stamp FSM:**
  - IDLE: if BTN[3] && memenable, latch cx, cy, r, shape and colour (writergb = 0 for eraser); x ← cx−r, y ← cy−r; busy ← 1; go to SCAN.
  - SCAN, enabled cycle (memenable && !fifofull):
    - writecounter ← (x,y); fifopush ← inside(x,y).
    - If x = cx+r: x ← cx−r and y ← y+1. Else x ← x+1.
    - After issuing (cx+r, cy+r): go to IDLE and set busy ← 0 on the following cycle.
  - SCAN, stall cycle: fifopush ← 0; x, y and writecounter hold. No pixel is lost or duplicated.
  - Pixels outside the footprint consume a cycle with fifopush = 0.
- **Continuous paint:** if BTN[3] is still held when the FSM reaches IDLE, the next stamp starts at the current cursor.
- **Reset mid-stamp:** FSM returns to IDLE and fifopush is 0 on the next cycle.

## Timing
- rgb has one-cycle latency from hpos/vpos/FB_RGB.
- Stamp duration is 1 latch cycle + (2r+1)² enabled SCAN cycles.
- fifopush is registered, lasts exactly one cycle per pixel, and is coincident with its address and writergb.
- A fifofull sampled high in cycle n blocks a push in cycle n+1.
- Movement takes effect on the cycle after the tick.

## Test plan
- Bench setup: SLOWNESS = 2 and default resolution for all scenarios.
- Reset: all outputs = reset values. Hold BTN = 4'b0101 for 8 ticks → cursor x = 328, y = 240.
- Clamp: cursor at x = 10, move left 3 ticks → x stays 10. Pulse size_next → r = 20 and x = 20 the same cycle.
- Square stamp: r = 10, cursor (100,100), pulse BTN[3], memenable = 1 → exactly 441 pushes, first at (90,90), last at (110,110), in raster order; busy drops 1 cycle after the last push.
- Circle stamp: shape = 2, r = 10 → 317 pushes, none with dx²+dy² > 100. Eraser stamp → writergb = 0 on every push.
- Backpressure: toggle fifofull randomly during a square stamp → the pushed address sequence is identical to the unstalled run, with no fifopush on any cycle following a fifofull = 1 cycle.
- Reset mid-stamp: assert reset at pixel 50 → fifopush = 0 and busy = 0 next cycle, and no further pushes occur.
